// File: rtl/block_mem_responder_if.sv
// Cache-miss-port to block-store handshake: block request in, block and completion pulse out.
// master = cache side, slave = memory responder.
interface block_mem_responder_if #(
    parameter int WA        = 32,
    parameter int BLOCKSIZE = 128
);
    logic                 mem_read;
    logic                 mem_write;
    logic [WA-1:0]        mem_request_addr;
    logic [BLOCKSIZE-1:0] mem_write_data;
    logic                 memory_ready;
    logic [BLOCKSIZE-1:0] memory_data;
    logic                 busy;

    modport master (
        output mem_read, mem_write, mem_request_addr, mem_write_data,
        input  memory_ready, memory_data, busy
    );

    modport slave (
        input  mem_read, mem_write, mem_request_addr, mem_write_data,
        output memory_ready, memory_data, busy
    );
endinterface

// File: rtl/block_mem_responder.sv
// Main-memory model behind the L1 miss port: latches one block request, waits a fixed
// latency, then writes the block store or returns a block with a one-cycle ready pulse.
//
// state | meaning
// IDLE  | no request in flight; samples mem_write/mem_read every cycle
// WAIT  | request latched; latency down-counter running, inputs ignored
// RESP  | memory_ready high for this one cycle; store written / block returned on entry
module block_mem_responder #(
    parameter int WA             = 32,
    parameter int BLOCKSIZE      = 128,
    parameter int BYTE_ADDR_BITS = 4,
    parameter int WAM            = 17,
    parameter int LATENCY        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    block_mem_responder_if.slave  bus
);
    localparam int LAT   = (LATENCY < 1) ? 1 : LATENCY;
    localparam int IW    = WAM - BYTE_ADDR_BITS;
    localparam int DEPTH = 1 << IW;
    localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    logic [CW-1:0]        counter;
    logic                 op_write;
    logic [IW-1:0]        index;
    logic [BLOCKSIZE-1:0] wdata_q;
    logic                 memory_ready_q;
    logic [BLOCKSIZE-1:0] memory_data_q;
    logic                 busy_q;

    logic [BLOCKSIZE-1:0] store [DEPTH];

    logic                 req;
    logic [IW-1:0]        req_index;
    logic                 enter_resp;
    logic                 resp_write;
    logic [IW-1:0]        resp_index;
    logic [BLOCKSIZE-1:0] resp_wdata;

    // Offset bits and bits above WAM-1 are deliberately dropped (aliasing wrap).
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_request_addr[WA-1:WAM],
                                bus.mem_request_addr[BYTE_ADDR_BITS-1:0]};

    assign req       = bus.mem_read | bus.mem_write;
    assign req_index = bus.mem_request_addr[WAM-1:BYTE_ADDR_BITS];

    // With LATENCY==1 a request goes straight from IDLE to RESP, so the store
    // access uses the live request instead of the latched copy.
    always_comb begin
        enter_resp = 1'b0;
        resp_write = op_write;
        resp_index = index;
        resp_wdata = wdata_q;
        case (state)
            IDLE: begin
                if (req && (LAT == 1)) begin
                    enter_resp = 1'b1;
                    resp_write = bus.mem_write;
                    resp_index = req_index;
                    resp_wdata = bus.mem_write_data;
                end
            end
            WAIT: begin
                if (counter == CW'(1)) begin
                    enter_resp = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            counter        <= '0;
            op_write       <= 1'b0;
            index          <= '0;
            wdata_q        <= '0;
            memory_ready_q <= 1'b0;
            memory_data_q  <= '0;
            busy_q         <= 1'b0;
        end else begin
            memory_ready_q <= enter_resp;
            if (enter_resp && !resp_write) begin
                memory_data_q <= store[resp_index];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        // write wins; a concurrent read stays asserted and is taken next IDLE
                        op_write <= bus.mem_write;
                        index    <= req_index;
                        wdata_q  <= bus.mem_write_data;
                        counter  <= CW'(LAT - 1);
                        busy_q   <= 1'b1;
                        state    <= (LAT == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    counter <= counter - CW'(1);
                    if (enter_resp) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Storage has no reset; a write aborted by reset never reaches this port.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && resp_write) begin
            store[resp_index] <= resp_wdata;
        end
    end

    assign bus.memory_ready = memory_ready_q;
    assign bus.memory_data  = memory_data_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: directed table, multi-cycle corner
// sequences, randomized traffic against an index-keyed block model, and a LATENCY=1 build.
module tb_block_mem_responder;
    localparam int LAT_A = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_mem_responder_if #(.WA(32), .BLOCKSIZE(128)) a_if ();
    block_mem_responder_if #(.WA(32), .BLOCKSIZE(128)) b_if ();

    block_mem_responder #(.LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    block_mem_responder #(.LATENCY(1))     dut_b (.clk(clk), .rst(rst), .bus(b_if));

    int checks = 0;
    int errors = 0;

    logic [127:0] model [int];
    logic [127:0] last_read;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_data;
        int           exp_lat;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int blk(input logic [31:0] addr);
        return int'(addr % 32'h2_0000) / 16;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? b_if.memory_ready : a_if.memory_ready;
    endfunction

    function automatic logic [127:0] dat(input bit sel);
        return sel ? b_if.memory_data : a_if.memory_data;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? b_if.busy : a_if.busy;
    endfunction

    task automatic set_req(input bit sel, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [127:0] wd);
        if (sel) begin
            b_if.mem_read = rd; b_if.mem_write = wr;
            b_if.mem_request_addr = addr; b_if.mem_write_data = wd;
        end else begin
            a_if.mem_read = rd; a_if.mem_write = wr;
            a_if.mem_request_addr = addr; a_if.mem_write_data = wd;
        end
    endtask

    // One request on an idle DUT; lat counts edges from the accepting edge to the
    // edge after which memory_ready is visible (0 if it never came).
    task automatic req(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [127:0] wd, output int lat, output logic [127:0] rdat);
        @(negedge clk);
        set_req(sel, rd, wr, addr, wd);
        lat  = 0;
        rdat = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) chk("busy_inflight", {127'b0, bsy(sel)}, 128'd1);
            if (rdy(sel)) begin
                lat  = i;
                rdat = dat(sel);
                break;
            end
        end
        set_req(sel, 1'b0, 1'b0, addr, wd);
        @(posedge clk); #1;
        chk("ready_not_consecutive", {127'b0, rdy(sel)}, 128'd0);
        chk("busy_low_idle", {127'b0, bsy(sel)}, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, first, second, seen;
        logic [127:0] rd, d55, dnew, wd;
        logic [31:0]  addr;
        int           keys [8];
        bit           written [8];

        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        last_read = '0;
        d55  = {16{8'h55}};
        dnew = {4{32'h1111_2222}};

        tbl[0] = '{0, 1, 32'h0000_0040, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 128'h0, LAT_A};
        tbl[1] = '{1, 0, 32'h0000_0040, '0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, LAT_A};
        tbl[2] = '{1, 0, 32'h0000_004C, '0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, LAT_A};
        tbl[3] = '{1, 0, 32'h0002_0040, '0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, LAT_A};
        tbl[4] = '{0, 1, 32'h0000_00C0, {4{32'hC0C0_A5A5}},
                   128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, LAT_A};
        tbl[5] = '{1, 0, 32'h0000_00C0, '0, {4{32'hC0C0_A5A5}}, LAT_A};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {127'b0, a_if.memory_ready}, 128'd0);
        chk("reset_data", a_if.memory_data, 128'd0);
        chk("reset_busy", {127'b0, a_if.busy}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed table: write, read-back, offset and alias reads
        for (int i = 0; i < 6; i++) begin
            req(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, rd);
            chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
            if (tbl[i].wr) model[blk(tbl[i].addr)] = tbl[i].wdata;
            else           last_read = rd;
        end

        // read+write together: write first, read pending through one IDLE cycle
        @(negedge clk);
        set_req(0, 1, 1, 32'h0000_0080, d55);
        first = 0; second = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (a_if.memory_ready) begin
                if (first == 0) begin
                    first = i;
                    chk("both_write_holds_data", a_if.memory_data, last_read);
                    a_if.mem_write = 1'b0;
                end else begin
                    second = i;
                    chk("both_read_new_data", a_if.memory_data, d55);
                    break;
                end
            end else if (first != 0 && i == first + 1) begin
                chk("both_idle_between", {127'b0, a_if.busy}, 128'd0);
            end
        end
        set_req(0, 0, 0, '0, '0);
        model[blk(32'h80)] = d55;
        last_read = d55;
        chk("both_first_latency", 128'(first), 128'(LAT_A));
        chk("both_gap", 128'(second - first), 128'(LAT_A + 1));
        @(posedge clk); #1;
        chk("both_no_consecutive", {127'b0, a_if.memory_ready}, 128'd0);

        // address changes during WAIT are ignored
        @(negedge clk);
        set_req(0, 1, 0, 32'h0000_0080, '0);
        @(posedge clk);
        @(negedge clk);
        a_if.mem_request_addr = 32'h0000_00C0;
        lat = 0;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (a_if.memory_ready) begin
                lat = i;
                chk("addr_change_data", a_if.memory_data, model[blk(32'h80)]);
                break;
            end
        end
        set_req(0, 0, 0, '0, '0);
        last_read = model[blk(32'h80)];
        chk("addr_change_latency", 128'(lat), 128'(LAT_A));
        @(posedge clk); #1;

        // reset mid-WAIT aborts a write; no stray pulse afterwards
        @(negedge clk);
        set_req(0, 0, 1, 32'h0000_0040, dnew);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 0, 0, '0, '0);
        @(posedge clk); #1;
        chk("midwait_reset_ready", {127'b0, a_if.memory_ready}, 128'd0);
        chk("midwait_reset_data", a_if.memory_data, 128'd0);
        chk("midwait_reset_busy", {127'b0, a_if.busy}, 128'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_read = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (a_if.memory_ready) seen = 1;
        end
        chk("no_pulse_after_reset", 128'(seen), 128'd0);
        req(0, 1, 0, 32'h0000_0040, '0, lat, rd);
        chk("dropped_write_latency", 128'(lat), 128'(LAT_A));
        chk("dropped_write_data", rd, model[blk(32'h40)]);
        last_read = rd;

        // randomized traffic against the block model
        for (int k = 0; k < 8; k++) begin
            keys[k]    = k * 811 + int'($urandom_range(0, 700));
            written[k] = 1'b0;
        end
        for (int n = 0; n < 40; n++) begin
            int  k;
            bit  do_wr;
            k     = int'($urandom_range(0, 7));
            do_wr = ($urandom_range(0, 1) == 1) || !written[k];
            addr  = {$urandom_range(0, 32767), 17'b0} | (32'(keys[k]) << 4)
                    | 32'($urandom_range(0, 15));
            wd    = {$urandom(), $urandom(), $urandom(), $urandom()};
            req(0, !do_wr, do_wr, addr, wd, lat, rd);
            chk($sformatf("rnd%0d_latency", n), 128'(lat), 128'(LAT_A));
            if (do_wr) begin
                chk($sformatf("rnd%0d_write_hold", n), rd, last_read);
                model[keys[k]] = wd;
                written[k]     = 1'b1;
            end else begin
                chk($sformatf("rnd%0d_read", n), rd, model[keys[k]]);
                last_read = model[keys[k]];
            end
        end

        // LATENCY=1 build: back-to-back reads
        req(1, 0, 1, 32'h0000_0000, {4{32'hB0B0_0000}}, lat, rd);
        chk("lat1_write0_latency", 128'(lat), 128'd1);
        req(1, 0, 1, 32'h0000_0010, {4{32'hB1B1_1111}}, lat, rd);
        chk("lat1_write1_latency", 128'(lat), 128'd1);
        @(negedge clk);
        set_req(1, 1, 0, 32'h0000_0000, '0);
        first = 0; second = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (b_if.memory_ready) begin
                if (first == 0) begin
                    first = i;
                    chk("lat1_read0_data", b_if.memory_data, {4{32'hB0B0_0000}});
                    b_if.mem_request_addr = 32'h0000_0010;
                end else begin
                    second = i;
                    chk("lat1_read1_data", b_if.memory_data, {4{32'hB1B1_1111}});
                    break;
                end
            end else if (first != 0 && i == first + 1) begin
                chk("lat1_busy_between", {127'b0, b_if.busy}, 128'd0);
            end
        end
        set_req(1, 0, 0, '0, '0);
        chk("lat1_first_latency", 128'(first), 128'd1);
        chk("lat1_gap", 128'(second - first), 128'd2);
        @(posedge clk); #1;
        chk("lat1_no_consecutive", {127'b0, b_if.memory_ready}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
